mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
Memory controller directly downstream of the MEM stage, and also serving instruction fetch. Accepts word/half/byte requests from MEM and word reads from IF, arbitrates between them, and serialises each request into byte accesses on a single-port, byte-wide synchronous RAM bus. Returns assembled read data with a one-cycle done pulse and holds busy while a transaction is in flight.

Parameters:
RAM_ADDR_W, 32, width of ram_a_o; byte address is mem/if address truncated to low RAM_ADDR_W bits

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
mem_r_enable_i  input  1  MEM load request (always 4-byte read at mem_addr_i)
mem_w_enable_i  input  1  MEM store request
mem_addr_i  input  32  MEM byte address (word-aligned for loads)
mem_w_data_i  input  32  store data; byte i taken from bits [8i+7:8i]
mem_mask_i  input  2  store size: 01 byte, 10 half, 11 word; ignored for reads
mem_r_data_o  output  32  assembled load data, valid with mem_done_o
mem_done_o  output  1  one-cycle completion pulse for MEM transaction
mem_busy_o  output  1  high whenever FSM not IDLE
if_r_enable_i  input  1  IF word-read request
if_addr_i  input  32  IF byte address
if_data_o  output  32  fetched word, valid with if_done_o
if_done_o  output  1  one-cycle completion pulse for IF transaction
if_busy_o  output  1  high whenever FSM not IDLE
ram_a_o  output  RAM_ADDR_W  RAM byte address
ram_wr_o  output  1  1 = write ram_dout_o this cycle, 0 = read
ram_dout_o  output  8  RAM write byte
ram_din_i  input  8  RAM read byte, valid one cycle after address issued

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0 (data, done, busy, ram_a_o, ram_wr_o, ram_dout_o); byte counter, latched request cleared. Reset mid-transaction aborts it; no done pulse.
- States: IDLE, ISSUE, TAIL, DONE.
- IDLE: sample requests each cycle. Priority: mem_w_enable_i, then mem_r_enable_i, then if_r_enable_i. mem_w and mem_r both high: write wins. Winner's address, data, size, owner latched; counter=0; go ISSUE. Byte count N: reads 4; writes 1/2/4 per mask; write with mask 00 -> N=4.
- ISSUE, cycle k (k=0..N-1): ram_a_o = base+k; writes: ram_wr_o=1, ram_dout_o = data byte k; reads: ram_wr_o=0. After k=N-1: write -> DONE; read -> TAIL.
- Read capture: byte issued in ISSUE cycle k is captured from ram_din_i in next cycle into bits [8k+7:8k] (little-endian). TAIL captures last byte then -> DONE.
- DONE: owner's done_o=1 for exactly one cycle, data output valid same cycle; other owner's done stays 0; -> IDLE. Data outputs hold last value until next completion.
- Latency from accept edge: word read done in 6th cycle after request cycle (request cycle 0 -> done cycle 6); word write cycle 5; half write cycle 3; byte write cycle 2.
- busy_o (both ports) = state != IDLE, includes DONE cycle. Requests while busy ignored, not queued; requester must re-present after done.
- Request present in same cycle as DONE is not accepted; earliest accept is the following IDLE cycle.
- Address increment is 32-bit modulo; ram_a_o = low RAM_ADDR_W bits; wrap at 0xFFFFFFFF -> 0x00000000.
- Outside ISSUE: ram_wr_o=0, ram_a_o=0, ram_dout_o=0.

Optional Feature:
MEMCTRL_IO_SINGLE_BYTE_EN: when defined, an MEM read with mem_addr_i[17:16]==2'b11 (I/O region) issues exactly one byte read at mem_addr_i unmodified (N=1), avoiding side-effecting reads of adjacent I/O registers; the byte is replicated into all four lanes of mem_r_data_o; done in cycle 3. IF reads unaffected. When undefined, I/O reads are ordinary 4-byte reads.

Test Plan:
- Word read: RAM[0x100..0x103]=11,22,33,44; mem_r_enable_i=1, addr 0x100 -> ram_a_o 0x100..0x103 cycles 1-4, mem_done_o pulse cycle 6, mem_r_data_o=0x44332211, if_done_o=0.
- Stores: mem_w, addr 0x204, data 0xAABBCCDD, mask 10 -> writes DD@0x204, CC@0x205, done cycle 3; mask 01 addr 0x207 -> only DD@0x207, done cycle 2.
- Arbitration: if_r_enable_i and mem_r_enable_i both high in IDLE -> MEM served first, if_busy_o=1 throughout; IF held high gets served afterwards, if_done_o pulses after mem_done_o.
- Reset mid-read: rst pulsed during ISSUE cycle 2 -> outputs 0 immediately, no done pulse; next request completes normally.
- Wrap: word read at 0xFFFFFFFE with RAM_ADDR_W=32 -> ram_a_o FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- With MEMCTRL_IO_SINGLE_BYTE_EN: read addr 0x30000, RAM byte 0x5A -> single RAM access, mem_r_data_o=0x5A5A5A5A, done cycle 3; without macro -> 4 accesses.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Bundle for mem_ctrl: MEM request/response, IF request/response and the byte-wide RAM bus.
// slave = controller view, master = environment (requesters + RAM) view.
interface mem_ctrl_if #(
  parameter int RAM_ADDR_W = 32
);
  logic                  mem_r_enable_i;
  logic                  mem_w_enable_i;
  logic [31:0]           mem_addr_i;
  logic [31:0]           mem_w_data_i;
  logic [1:0]            mem_mask_i;
  logic [31:0]           mem_r_data_o;
  logic                  mem_done_o;
  logic                  mem_busy_o;
  logic                  if_r_enable_i;
  logic [31:0]           if_addr_i;
  logic [31:0]           if_data_o;
  logic                  if_done_o;
  logic                  if_busy_o;
  logic [RAM_ADDR_W-1:0] ram_a_o;
  logic                  ram_wr_o;
  logic [7:0]            ram_dout_o;
  logic [7:0]            ram_din_i;

  modport slave (
    input  mem_r_enable_i, mem_w_enable_i, mem_addr_i, mem_w_data_i, mem_mask_i,
    output mem_r_data_o, mem_done_o, mem_busy_o,
    input  if_r_enable_i, if_addr_i,
    output if_data_o, if_done_o, if_busy_o,
    output ram_a_o, ram_wr_o, ram_dout_o,
    input  ram_din_i
  );

  modport master (
    output mem_r_enable_i, mem_w_enable_i, mem_addr_i, mem_w_data_i, mem_mask_i,
    input  mem_r_data_o, mem_done_o, mem_busy_o,
    output if_r_enable_i, if_addr_i,
    input  if_data_o, if_done_o, if_busy_o,
    input  ram_a_o, ram_wr_o, ram_dout_o,
    output ram_din_i
  );
endinterface

// File: rtl/mem_ctrl.sv
// MEM/IF memory controller serialising word/half/byte requests onto a byte-wide sync RAM.
// Optional: MEMCTRL_IO_SINGLE_BYTE_EN makes MEM reads in the I/O region (addr[17:16]==11) single-byte.
module mem_ctrl #(
  parameter int RAM_ADDR_W = 32
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_TAIL, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_buf, r_mem_data, r_if_data;
  logic [1:0]  r_cnt, r_last;
  logic        r_wr, r_own_if, r_single;

  logic        w_req, w_io, w_mem_req;
  logic [1:0]  w_req_last, w_cap_idx;
  logic        w_cap_en;
  logic [31:0] w_byte_addr, w_wsh, w_asm;

`ifdef MEMCTRL_IO_SINGLE_BYTE_EN
  assign w_io = (bus.mem_addr_i[17:16] == 2'b11);
`else
  assign w_io = 1'b0;
`endif

  assign w_mem_req = bus.mem_w_enable_i | bus.mem_r_enable_i;
  assign w_req     = w_mem_req | bus.if_r_enable_i;

  // r_last holds N-1 so the ISSUE counter compare stays 2 bits wide
  always_comb begin
    w_req_last = 2'd3;
    if (bus.mem_w_enable_i) begin
      case (bus.mem_mask_i)
        2'b01:   w_req_last = 2'd0;
        2'b10:   w_req_last = 2'd1;
        default: w_req_last = 2'd3;
      endcase
    end else if (bus.mem_r_enable_i && w_io) begin
      w_req_last = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_next = S_ISSUE;
      S_ISSUE: if (r_cnt == r_last) w_next = r_wr ? S_DONE : S_TAIL;
      S_TAIL:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Byte issued in ISSUE cycle k arrives one cycle later; TAIL picks up the final byte
  always_comb begin
    w_cap_en  = ((r_state == S_ISSUE) && (r_cnt != 2'd0) && !r_wr) || (r_state == S_TAIL);
    w_cap_idx = (r_state == S_TAIL) ? r_last : (r_cnt - 2'd1);
    w_asm     = r_buf;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_cap_idx == 2'(i)) w_asm[8*i +: 8] = bus.ram_din_i;
    end
    if ((r_state == S_TAIL) && r_single) w_asm = {4{bus.ram_din_i}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_buf      <= '0;
      r_mem_data <= '0;
      r_if_data  <= '0;
      r_cnt      <= '0;
      r_last     <= '0;
      r_wr       <= 1'b0;
      r_own_if   <= 1'b0;
      r_single   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr   <= w_mem_req ? bus.mem_addr_i : bus.if_addr_i;
            r_wdata  <= bus.mem_w_data_i;
            r_wr     <= bus.mem_w_enable_i;
            r_own_if <= ~w_mem_req;
            r_single <= ~bus.mem_w_enable_i & bus.mem_r_enable_i & w_io;
            r_last   <= w_req_last;
            r_cnt    <= '0;
            r_buf    <= '0;
          end
        end
        S_ISSUE: r_cnt <= r_cnt + 2'd1;
        default: ;
      endcase
      if (w_cap_en) r_buf <= w_asm;
      if (r_state == S_TAIL) begin
        if (r_own_if) r_if_data  <= w_asm;
        else          r_mem_data <= w_asm;
      end
    end
  end

  assign w_byte_addr = r_addr + {30'd0, r_cnt};
  assign w_wsh       = r_wdata >> {r_cnt, 3'b000};

  assign bus.ram_a_o    = (r_state == S_ISSUE) ? w_byte_addr[RAM_ADDR_W-1:0] : '0;
  assign bus.ram_wr_o   = (r_state == S_ISSUE) && r_wr;
  assign bus.ram_dout_o = ((r_state == S_ISSUE) && r_wr) ? w_wsh[7:0] : '0;

  assign bus.mem_done_o   = (r_state == S_DONE) && !r_own_if;
  assign bus.if_done_o    = (r_state == S_DONE) && r_own_if;
  assign bus.mem_busy_o   = (r_state != S_IDLE);
  assign bus.if_busy_o    = (r_state != S_IDLE);
  assign bus.mem_r_data_o = r_mem_data;
  assign bus.if_data_o    = r_if_data;

endmodule
